tdm_framer: RTL and testbench
=============================

Name: tdm_framer

Overview:
- Upstream TDM transmit stage. Accepts one byte per timeslot over a valid/ready handshake and serialises it MSB-first onto a single-bit stream.
- Drives a one-cycle frame sync pulse that marks the frame boundary for the downstream serial-to-parallel receiver.
- Frame = NUM_SLOTS slots x SLOT_W bits, one bit per clk. Underrun inserts an idle byte so that frame timing never slips.

Parameters:
- NUM_SLOTS, 32, timeslots per frame; power of 2, >= 2.
- SLOT_W, 8, bits per timeslot; power of 2, >= 2.
- IDLE_BYTE, 8'hFF, byte sent in a slot when no input data is available.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  level; high = run frames, low = stop at the next frame boundary.
- in_data  input  SLOT_W  byte for the next slot to be loaded.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle (transfer = in_valid & in_ready).
- bstream  output  1  serial data, MSB of each slot first.
- sync  output  1  one-cycle frame marker.
- slot_num  output  $clog2(NUM_SLOTS)  slot whose bit is currently on bstream.
- underrun  output  1  one-cycle pulse when IDLE_BYTE is substituted.

Behaviour:
- Reset (rst=0, async): state=IDLE, bstream=0, sync=0, slot_num=0, underrun=0, holding register empty, bit/slot counters=0.
- The block has a one-entry holding register (hold, hold_full). The shift register drives bstream.
- in_ready = ~hold_full | load. Here load = cycle in which the shift register reloads. A transfer in a load cycle refills hold in that same cycle. in_ready is 1 in IDLE when hold is empty.
- FSM states: IDLE, START, RUN.
  - IDLE: bstream=0, sync=0. enable=1 -> START.
  - START (1 cycle): sync=1, bstream=0, load=1. Shift reg <= hold if full, else IDLE_BYTE with underrun=1. Counters=0. Next state RUN.
  - RUN: each cycle bstream=shift[SLOT_W-1], shift left, bit_cnt++.
    - At bit_cnt==SLOT_W-1: load=1, slot_cnt++ (wraps NUM_SLOTS-1 -> 0).
    - Last bit of the frame (slot_cnt==NUM_SLOTS-1, bit_cnt==SLOT_W-1): sync=1 concurrently with that bit. The first bit of slot 0 follows on the next cycle.
    - At that last bit, if enable=0: go to IDLE, no load, hold is retained.
    - A mid-frame enable drop has no effect until the frame completes.
- Frame period = NUM_SLOTS*SLOT_W cycles, with sync exactly once per period.
- slot_num = slot_cnt (registered), and is 0 during START.
- Latency: a byte in hold at a load edge appears at bstream MSB on the next cycle.
- Simultaneous load and transfer: the old hold goes to shift and the new byte goes to hold, with no bubble.
- Async reset mid-frame: everything clears immediately. No partial slot is completed.

Optional Feature:
- Macro TDM_FRAMER_FAS_EN.
- When defined:
  - Slot 0 of every frame carries a fixed frame-alignment byte 8'h1B and never consumes hold.
  - in_ready stays 0 while the slot-0 load is pending.
  - Underrun never fires for slot 0.
  - The START load uses 8'h1B.
- When not defined: slot 0 is an ordinary data slot.

Decomposition:
- Package tdm_pkg holds:
  - state_e enum {IDLE, START, RUN};
  - localparams SLOT_W, NUM_SLOTS, SLOT_IDX_W, BIT_IDX_W, IDLE_BYTE, FAS_BYTE.
  - These are shared with the receiver.
- Sub-module: tdm_shift_out (SLOT_W-bit parallel-load, MSB-first shift register with load/shift enables). The FSM, counters and hold stay in the top.

Test Plan:
- Reset, then enable=1, in_valid=1 streaming 0x00..0x1F -> sync at cycle 0, bstream carries each byte MSB-first, slot_num 0..31, sync again exactly 256 cycles later, underrun never asserts.
- in_valid=0 throughout slot 3 load -> slot 3 bits = 8'hFF, one underrun pulse at that load, following slots resume with supplied data.
- Hold full, in_valid=1 at a load cycle -> in_ready=1, no lost or duplicated byte. Backpressure test: hold full, no load -> in_ready=0, data held stable.
- enable dropped at slot 10 -> frame completes through slot 31 with sync on the last bit, then bstream=0 and sync=0 in IDLE. Re-enable -> START sync, and the retained hold byte is sent first.
- rst asserted mid-slot 5 -> bstream, sync, slot_num and underrun go to 0 asynchronously. After release and enable, a new frame starts cleanly.
- With TDM_FRAMER_FAS_EN: slot 0 = 8'h1B every frame, the input byte sequence shifts to slots 1..31, in_ready=0 at the slot-0 load.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM framing constants and FSM state type, used by both the framer and the receiver.
package tdm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN
   } state_e;

   localparam int SLOT_W     = 8;
   localparam int NUM_SLOTS  = 32;
   localparam int SLOT_IDX_W = $clog2(NUM_SLOTS);
   localparam int BIT_IDX_W  = $clog2(SLOT_W);

   localparam logic [SLOT_W-1:0] IDLE_BYTE = 8'hFF;
   localparam logic [7:0]        FAS_BYTE  = 8'h1B;

endpackage

// File: rtl/tdm_shift_out.sv
// Parallel-load, MSB-first output shift register; a load takes priority over a shift.
module tdm_shift_out #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] data_i,
   output logic         msb_o
);

   logic [W-1:0] shift_q, shift_d;

   always_comb begin
      shift_d = shift_q;
      if (load_i) begin
         shift_d = data_i;
      end else if (shift_i) begin
         shift_d = {shift_q[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign msb_o = shift_q[W-1];

endmodule

// File: rtl/tdm_framer.sv
// TDM transmit framer: bytes in over valid/ready, serial MSB-first out with a frame sync pulse.
// Optional frame-alignment byte in slot 0 is enabled by defining TDM_FRAMER_FAS_EN.
module tdm_framer #(
   parameter int                NUM_SLOTS = tdm_pkg::NUM_SLOTS,
   parameter int                SLOT_W    = tdm_pkg::SLOT_W,
   parameter logic [SLOT_W-1:0] IDLE_BYTE = tdm_pkg::IDLE_BYTE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [SLOT_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         bstream,
   output logic                         sync,
   output logic [$clog2(NUM_SLOTS)-1:0] slot_num,
   output logic                         underrun
);

   import tdm_pkg::*;

   localparam int SIW = $clog2(NUM_SLOTS);
   localparam int BIW = $clog2(SLOT_W);
   localparam logic [SIW-1:0] LAST_SLOT = SIW'(NUM_SLOTS - 1);
   localparam logic [BIW-1:0] LAST_BIT  = BIW'(SLOT_W - 1);

   state_e            state_q, state_d;
   logic [BIW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [SIW-1:0]    slot_cnt_q, slot_cnt_d;
   logic [SLOT_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              load, shift_en, last_bit, last_slot;
   logic              fas_load, data_load, xfer, shift_msb;
   logic [SLOT_W-1:0] load_data;

   assign last_bit  = (bit_cnt_q == LAST_BIT);
   assign last_slot = (slot_cnt_q == LAST_SLOT);

   // The frame ends on the last bit; a low enable there parks the FSM without reloading.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      slot_cnt_d = slot_cnt_q;
      load       = 1'b0;
      shift_en   = 1'b0;
      sync       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = START;
            end
         end
         START: begin
            sync       = 1'b1;
            load       = 1'b1;
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
            state_d    = RUN;
         end
         RUN: begin
            shift_en  = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
               slot_cnt_d = slot_cnt_q + 1'b1;
               load       = 1'b1;
               if (last_slot) begin
                  sync = 1'b1;
                  if (!enable) begin
                     load    = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef TDM_FRAMER_FAS_EN
   localparam logic [SLOT_W-1:0] FAS_WORD = SLOT_W'(FAS_BYTE);
   assign fas_load = load & ((state_q == START) | (last_bit & last_slot));
`else
   assign fas_load = 1'b0;
`endif

   assign data_load = load & ~fas_load;
   assign underrun  = data_load & ~hold_full_q;
   assign in_ready  = ~fas_load & (~hold_full_q | load);
   assign xfer      = in_valid & in_ready;

   // A transfer in a load cycle refills hold while the old byte moves into the shifter.
   always_comb begin
      load_data   = hold_full_q ? hold_q : IDLE_BYTE;
`ifdef TDM_FRAMER_FAS_EN
      if (fas_load) begin
         load_data = FAS_WORD;
      end
`endif
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (data_load) begin
         hold_full_d = 1'b0;
      end
      if (xfer) begin
         hold_d      = in_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         slot_cnt_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         slot_cnt_q  <= slot_cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   tdm_shift_out #(
      .W (SLOT_W)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .shift_i (shift_en),
      .data_i  (load_data),
      .msb_o   (shift_msb)
   );

   assign bstream  = (state_q == RUN) & shift_msb;
   assign slot_num = slot_cnt_q;

endmodule

// File: tb/tb_tdm_framer.sv
// Scoreboard bench for tdm_framer: accepted bytes are queued, a monitor rebuilds slots from bstream.
module tb_tdm_framer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, bstream, sync, underrun;
   logic [4:0] slot_num;

   typedef struct packed {
      logic [7:0] data;
      logic       under;
   } exp_t;

   exp_t       expQ[$];
   int         testsRun = 0;
   int         testsFailed = 0;
   int         cycleCount = 0;

   logic       running = 1'b0;
   int         bitIdx = 0;
   int         slotIdx = 0;
   int         lastSync = 0;
   logic [7:0] acc = 8'h00;
   logic       pendUnder = 1'b0;
   logic       slotUnder = 1'b0;
   exp_t       popped;

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   tdm_framer dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .bstream  (bstream),
      .sync     (sync),
      .slot_num (slot_num),
      .underrun (underrun)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Offer one byte and wait for the handshake; the accepted byte becomes the next expected slot.
   task automatic applyStimulus(input logic [7:0] b);
      bit done = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            expQ.push_back('{data: b, under: 1'b0});
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL handshake_timeout: byte 0x%0h not accepted, expected in_ready within 600 cycles", b);
      end
   endtask

   task automatic pushIdle();
      expQ.push_back('{data: 8'hFF, under: 1'b1});
   endtask

   // Monitor: tracks frame position independently and compares each completed slot with the queue.
   always @(negedge clk) begin
      if (!rst) begin
         running   = 1'b0;
         bitIdx    = 0;
         slotIdx   = 0;
         pendUnder = 1'b0;
      end else if (!running) begin
         checkOutput("idle_bstream", bstream, 0);
         checkOutput("idle_slot_num", slot_num, 0);
         if (sync) begin
            pendUnder = underrun;
            running   = 1'b1;
            bitIdx    = 0;
            slotIdx   = 0;
            lastSync  = cycleCount;
         end else begin
            checkOutput("idle_underrun", underrun, 0);
         end
      end else begin
         if (bitIdx == 0) begin
            slotUnder = pendUnder;
            pendUnder = 1'b0;
            acc       = 8'h00;
         end
         acc = {acc[6:0], bstream};
         checkOutput("slot_num", slot_num, slotIdx);
         checkOutput("sync", sync, (bitIdx == 7 && slotIdx == 31));
         if (bitIdx != 7) begin
            checkOutput("underrun_midslot", underrun, 0);
            bitIdx++;
         end else begin
`ifdef TDM_FRAMER_FAS_EN
            if (slotIdx == 0) begin
               checkOutput("fas_byte", acc, 8'h1B);
               checkOutput("fas_underrun", slotUnder, 0);
            end else
`endif
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL scoreboard_empty: slot %0d carried 0x%0h, expected no slot", slotIdx, acc);
            end else begin
               popped = expQ.pop_front();
               checkOutput($sformatf("slot%0d_byte", slotIdx), acc, popped.data);
               checkOutput($sformatf("slot%0d_underrun", slotIdx), slotUnder, popped.under);
            end
            if (slotIdx == 31) begin
               checkOutput("sync_period", cycleCount - lastSync, 256);
               lastSync = cycleCount;
               if (!enable) begin
                  running = 1'b0;
               end
            end
            pendUnder = underrun;
            slotIdx   = (slotIdx + 1) % 32;
            bitIdx    = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_bstream", bstream, 0);
      checkOutput("reset_sync", sync, 0);
      checkOutput("reset_slot_num", slot_num, 0);
      checkOutput("reset_underrun", underrun, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Frame 1 streams 0x00..0x1F; frame 2 underruns slot 3.
      enable = 1'b1;
      for (int i = 0; i < 32; i++) applyStimulus(8'(i));
      applyStimulus(8'h20);
      applyStimulus(8'h21);
      applyStimulus(8'h22);
      pushIdle();
      repeat (16) @(posedge clk);
      #1;
      for (int i = 8'h23; i <= 8'h3E; i++) applyStimulus(8'(i));

      // Frame 3: enable drops during slot 10, the frame still completes.
      for (int i = 8'h3F; i <= 8'h4A; i++) applyStimulus(8'(i));
      enable = 1'b0;
      for (int i = 8'h4B; i <= 8'h5F; i++) applyStimulus(8'(i));
      repeat (12) @(posedge clk);
      #1;

      in_data  = 8'h60;
      in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("backpressure_in_ready", in_ready, 0);
         checkOutput("idle_sync", sync, 0);
      end
      @(posedge clk);
      #1;
      enable = 1'b1;
      applyStimulus(8'h60);
      for (int i = 8'h61; i <= 8'h65; i++) applyStimulus(8'(i));

      // Asynchronous reset in the middle of slot 5.
      repeat (3) @(posedge clk);
      #2;
      rst    = 1'b0;
      enable = 1'b0;
      #1;
      checkOutput("midreset_bstream", bstream, 0);
      checkOutput("midreset_sync", sync, 0);
      checkOutput("midreset_slot_num", slot_num, 0);
      checkOutput("midreset_underrun", underrun, 0);
      checkOutput("midreset_in_ready", in_ready, 1);
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Clean frame after reset, stopping at its end with hold drained.
      enable = 1'b1;
      for (int i = 8'hA0; i <= 8'hAB; i++) applyStimulus(8'(i));
      enable = 1'b0;
      for (int i = 8'hAC; i <= 8'hBF; i++) applyStimulus(8'(i));
      repeat (24) @(posedge clk);
      #1;
      checkOutput("final_queue_empty", expQ.size(), 0);
      checkOutput("final_in_ready", in_ready, 1);
      checkOutput("final_bstream", bstream, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
